// File: rtl/cnn_multi_ctrl.sv
// cnn_multi_ctrl: ICB-slave control/status registers for NUM_CH CNN accelerator channels.
// Optional macro CNN_CYCLE_CNT_EN builds the per-channel run-cycle counters; without it CYCLES reads 0.
module cnn_multi_ctrl #(
  parameter int NUM_CH = 4,
  parameter int MODE_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_icb_cmd_valid,
  output logic                     cfg_icb_cmd_ready,
  input  logic [31:0]              cfg_icb_cmd_addr,
  input  logic                     cfg_icb_cmd_read,
  input  logic [31:0]              cfg_icb_cmd_wdata,
  input  logic [3:0]               cfg_icb_cmd_wmask,
  output logic                     cfg_icb_rsp_valid,
  input  logic                     cfg_icb_rsp_ready,
  output logic [31:0]              cfg_icb_rsp_rdata,
  output logic                     cfg_icb_rsp_err,
  output logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        ch_start,
  output logic [NUM_CH*MODE_W-1:0] ch_mode,
  input  logic [NUM_CH-1:0]        ch_done,
  output logic                     irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ch_state_e;
  typedef enum logic [1:0] {REG_CTRL, REG_STATUS, REG_IRQ_EN, REG_CYCLES} reg_sel_e;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [MODE_W-1:0] mode_q  [NUM_CH];
  logic [MODE_W-1:0] mode_d  [NUM_CH];
  logic [NUM_CH-1:0] enable_q, enable_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] done_q, done_d, ovr_q, ovr_d, start_q, start_d;
`ifdef CNN_CYCLE_CNT_EN
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
`endif
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              hsk, idx_ok, wr;
  logic [7:0]        idx;
  reg_sel_e          reg_sel;
  logic [31:0]       rd_word;
  logic [NUM_CH-1:0] wr_ctrl, wr_stat, wr_irq, en_post, go, ack;
  logic              unused_bits;

  assign idx               = cfg_icb_cmd_addr[11:4];
  assign reg_sel           = reg_sel_e'(cfg_icb_cmd_addr[3:2]);
  assign idx_ok            = ({24'd0, idx} < 32'(NUM_CH));
  assign cfg_icb_cmd_ready = ~rsp_valid_q;
  assign hsk               = cfg_icb_cmd_valid & cfg_icb_cmd_ready;
  assign wr                = hsk & ~cfg_icb_cmd_read & idx_ok;
  assign unused_bits       = ^{cfg_icb_cmd_addr[31:12], cfg_icb_cmd_addr[1:0],
                               cfg_icb_cmd_wdata, cfg_icb_cmd_wmask[3:2]};

  assign cfg_icb_rsp_valid = rsp_valid_q;
  assign cfg_icb_rsp_rdata = rsp_rdata_q;
  assign cfg_icb_rsp_err   = rsp_err_q;
  assign ch_enable         = enable_q;
  assign ch_start          = start_q;
  assign irq               = |(done_q & irq_en_q);

  always_comb begin
    ch_mode = '0;
    for (int c = 0; c < NUM_CH; c++) ch_mode[c*MODE_W +: MODE_W] = mode_q[c];
  end

  // NOTE: every signal driven here gets a default before any conditional, so no latches are inferred.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx == 8'(c)) begin
        case (reg_sel)
          REG_CTRL: begin
            rd_word[0]             = enable_q[c];
            rd_word[8 +: MODE_W]   = mode_q[c];
          end
          REG_STATUS: rd_word[2:0] = {ovr_q[c], done_q[c], state_q[c] == ST_RUN};
          REG_IRQ_EN: rd_word[0]   = irq_en_q[c];
          REG_CYCLES: begin
`ifdef CNN_CYCLE_CNT_EN
            rd_word = 32'(cnt_q[c]);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Per-channel write decode; en_post is the enable value after this cycle's write.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ctrl[c] = wr && (idx == 8'(c)) && (reg_sel == REG_CTRL);
      wr_stat[c] = wr && (idx == 8'(c)) && (reg_sel == REG_STATUS);
      wr_irq[c]  = wr && (idx == 8'(c)) && (reg_sel == REG_IRQ_EN);
      en_post[c] = (wr_ctrl[c] && cfg_icb_cmd_wmask[0]) ? cfg_icb_cmd_wdata[0] : enable_q[c];
      go[c]      = wr_ctrl[c] & cfg_icb_cmd_wmask[0] & cfg_icb_cmd_wdata[1] & en_post[c];
      ack[c]     = wr_stat[c] & cfg_icb_cmd_wmask[0] & cfg_icb_cmd_wdata[1];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]  = state_q[c];
      mode_d[c]   = mode_q[c];
      enable_d[c] = en_post[c];
      start_d[c]  = 1'b0;
      irq_en_d[c] = (wr_irq[c] && cfg_icb_cmd_wmask[0]) ? cfg_icb_cmd_wdata[0] : irq_en_q[c];
      done_d[c]   = done_q[c] & ~ack[c];
      ovr_d[c]    = ovr_q[c] & ~(wr_stat[c] & cfg_icb_cmd_wmask[0] & cfg_icb_cmd_wdata[2]);
`ifdef CNN_CYCLE_CNT_EN
      cnt_d[c]    = cnt_q[c];
`endif
      if (wr_ctrl[c] && cfg_icb_cmd_wmask[1] && state_q[c] != ST_RUN)
        mode_d[c] = cfg_icb_cmd_wdata[8 +: MODE_W];
      // A done pulse outside RUN means the core finished without being started.
      if (ch_done[c] && state_q[c] != ST_RUN) ovr_d[c] = 1'b1;
      if (!en_post[c]) begin
        state_d[c] = ST_IDLE;
      end else begin
        case (state_q[c])
          ST_IDLE: if (go[c]) begin
            state_d[c] = ST_RUN;
            start_d[c] = 1'b1;
`ifdef CNN_CYCLE_CNT_EN
            cnt_d[c]   = '0;
`endif
          end
          ST_RUN: begin
`ifdef CNN_CYCLE_CNT_EN
            if (cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + 1'b1;
`endif
            if (ch_done[c]) begin
              done_d[c]  = 1'b1;
              state_d[c] = ST_DONE;
            end
          end
          ST_DONE: begin
            if (go[c]) begin
              done_d[c]  = 1'b0;
              state_d[c] = ST_RUN;
              start_d[c] = 1'b1;
`ifdef CNN_CYCLE_CNT_EN
              cnt_d[c]   = '0;
`endif
            end else if (ch_done[c]) begin
              done_d[c]  = 1'b1;
            end else if (ack[c]) begin
              state_d[c] = ST_IDLE;
            end
          end
          default: state_d[c] = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_q && cfg_icb_rsp_ready) rsp_valid_d = 1'b0;
    if (hsk) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~idx_ok;
      rsp_rdata_d = (cfg_icb_cmd_read && idx_ok) ? rd_word : 32'd0;
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= '0;
      irq_en_q    <= '0;
      done_q      <= '0;
      ovr_q       <= '0;
      start_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      // NOTE: these per-channel arrays are plain flops, not RAM, so they are reset like any register.
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        mode_q[c]  <= '0;
`ifdef CNN_CYCLE_CNT_EN
        cnt_q[c]   <= '0;
`endif
      end
    end else begin
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        mode_q[c]  <= mode_d[c];
`ifdef CNN_CYCLE_CNT_EN
        cnt_q[c]   <= cnt_d[c];
`endif
      end
    end
  end

endmodule

// File: doc/cnn_multi_ctrl.md
Name: cnn_multi_ctrl

Overview:
- Parametrised ICB-slave control/status register block for NUM_CH CNN accelerator channels. It sits between the e203 ICB config bus (base 0x1004_2000) and the CNN cores.
- Each channel has: enable, start pulse, mode field, busy/done/overrun status, done interrupt, and a run-cycle counter.
- Proper single-outstanding ICB handshake, with error response on unmapped addresses.

Parameters:
- NUM_CH, 4, number of CNN channels (1..8).
- MODE_W, 4, per-channel mode field width (1..8).
- CNT_W, 32, cycle-counter width (8..32).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_icb_cmd_valid  in  1  command valid.
- cfg_icb_cmd_ready  out  1  command ready.
- cfg_icb_cmd_addr  in  32  byte address; bits [11:0] decoded.
- cfg_icb_cmd_read  in  1  1 = read, 0 = write.
- cfg_icb_cmd_wdata  in  32  write data.
- cfg_icb_cmd_wmask  in  4  byte-lane write mask.
- cfg_icb_rsp_valid  out  1  response valid.
- cfg_icb_rsp_ready  in  1  response ready.
- cfg_icb_rsp_rdata  out  32  read data.
- cfg_icb_rsp_err  out  1  unmapped-address error.
- ch_enable  out  NUM_CH  per-channel enable level.
- ch_start  out  NUM_CH  one-cycle start pulse.
- ch_mode  out  NUM_CH*MODE_W  per-channel mode; channel c uses bits [c*MODE_W +: MODE_W].
- ch_done  in  NUM_CH  one-cycle done pulse from each core.
- irq  out  1  OR over channels of (done & irq_en).

Behaviour:
- Reset: all outputs 0, cmd_ready=1, all registers 0, all channels IDLE.
- Handshake:
  - hsk = cmd_valid & cmd_ready; cmd_ready = ~rsp_valid (one outstanding transaction).
  - rsp_valid rises the cycle after hsk and holds until rsp_ready; rdata and err are stable while it is held.
  - Write side effects apply in the hsk cycle and are visible the next cycle.
- Decode:
  - Channel index = addr[11:4]; register = addr[3:2]; addr[1:0] ignored.
  - Index >= NUM_CH gives err=1 and rdata=0; a write there has no effect.
- Registers (per channel):
  - 0x0 CTRL:
    - [0] enable, RW, byte lane 0.
    - [1] start, write-1 only, reads 0.
    - [8 +: MODE_W] mode, RW, byte lane 1; a write to mode is ignored while the channel is in RUN.
  - 0x4 STATUS:
    - [0] busy, RO.
    - [1] done, W1C.
    - [2] overrun, W1C.
  - 0x8 IRQ_EN: [0] done-interrupt enable, RW.
  - 0xC CYCLES: RO, zero-extended to 32 bits.
- Per-channel FSM:
  - IDLE:
    - start=1 written with enable=1 (post-write value) → ch_start pulse next cycle, counter cleared, → RUN.
    - Start with enable=0 is ignored.
  - RUN:
    - busy=1; the counter increments each cycle and saturates at all-ones.
    - ch_done → done=1, → DONE.
    - A start write is ignored.
  - DONE:
    - W1C of done → IDLE.
    - A start write clears done, pulses ch_start, clears the counter, → RUN.
- Enable cleared (written 0) in any state → IDLE next cycle; busy=0; done, overrun and counter are retained.
- ch_done in IDLE or DONE: overrun=1; FSM unchanged.
- Simultaneous events:
  - W1C done with ch_done in the same cycle: set wins, done stays 1.
  - Enable clear with ch_done in RUN: enable clear wins, → IDLE, done not set.
  - Writes to one channel never affect other channels.
- rst asserted mid-transaction: rsp_valid dropped, all state back to the reset values next edge.

Optional Feature:
- Macro CNN_CYCLE_CNT_EN.
- Defined: per-channel CNT_W-bit run-cycle counter implemented as above.
- Undefined: no counter logic; CYCLES reads 0 with err=0; everything else unchanged.

Test Plan:
- Reset, then read ch0 STATUS (0x004) → rdata=0, err=0. Read ch0 CTRL with rsp_ready held low 3 cycles → rsp_valid stays 1, cmd_ready stays 0, rdata stable.
- Write ch1 CTRL=0x0000_0301 (mask 4'b0011) then CTRL=0x0000_0303 → ch_enable[1]=1, ch_mode ch1=3, single ch_start[1] pulse. Read CTRL → 0x0000_0301.
- ch2 started, ch_done[2] pulsed after 10 cycles, IRQ_EN=1 → STATUS=0x2, irq=1. With CNN_CYCLE_CNT_EN, CYCLES reads 10 (±1 per counting convention). W1C 0x2 → irq=0, FSM IDLE.
- ch_done[0] pulsed while ch0 IDLE → STATUS=0x4. W1C done and ch_done[3] in the same cycle on ch3 in DONE → done remains 1.
- Read address 0x0F0 with NUM_CH=4 → err=1, rdata=0. A write there leaves all registers unchanged.
- Write ch0 CTRL=0 while RUN, ch_done[0] in the same cycle → busy=0, done=0, ch_enable[0]=0. Without CNN_CYCLE_CNT_EN, CYCLES reads 0.
